led_scheduler: RTL
==================

# led_scheduler

Round-robin scheduler for the board LEDs (LED5, LED4, LED2). It shares them between four requester channels, each supplying a 3-bit pattern. It grants one channel at a time for a fixed dwell period and inserts a blank gap between owners. It sits between the pattern-generating logic and the top-level LED pins.

## Interface
- `TICK_DIV`, default 12000: clk cycles per tick; legal range ≥2.
- `DWELL`, default 100: ticks per grant; legal range ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request per channel; level-sensitive.
- `pat`  in  12  patterns; channel i occupies `pat[3*i+2:3*i]`; bit2→LED5, bit1→LED4, bit0→LED2.
- `grant`  out  4  one-hot owner; all-zero when no channel is granted.
- `busy`  out  1  high in GRANT and GAP.
- `LED5`, `LED4`, `LED2`  out  1 each  registered LED drives, active-high.

## Operation
- FSM states: IDLE, GRANT, GAP. Encoding is free.
- **IDLE**
  - If any `req` bit is high, pick the winner round-robin.
  - Search starts at `(last+1) mod 4`, where `last` is the most recent owner; `last` resets to 3, so `req[0]` has first priority.
  - Go to GRANT. Load `grant`. Latch the winner's `pat` slice into the LED registers.
- **GRANT**
  - LEDs show the latched pattern. `pat` changes while granted are ignored.
  - Exit to GAP after DWELL ticks.
  - Exit to GAP early on the cycle the owner's `req` is sampled low.
- **GAP**
  - `grant` = 0. LEDs = 0.
  - Lasts exactly 1 tick, then re-arbitrates like IDLE.
  - If no request is pending, go to IDLE.
  - A sole requester is regranted after the gap.
- Prescaler: counter 0..TICK_DIV-1. It restarts at 0 on every state entry, so durations are exact.
- Dwell counter: counts ticks in GRANT and clears on entry to GRANT.
- Counter widths: `$clog2(TICK_DIV)` and `$clog2(DWELL+1)`. No wrap is visible outside the block.
- Requests arriving during GRANT or GAP are not lost: they are evaluated at the next arbitration point.
- Simultaneous events:
  - Owner dropping `req` on the same cycle dwell expires → one GAP, not two.
  - New requests on the gap's final cycle participate in that arbitration.

## Timing
- Reset (async assert, sync release) values: FSM=IDLE, `grant`=0, `busy`=0, LEDs=0, `last`=3, counters=0.
- Reset mid-grant forces all of the above immediately, without waiting for a clock edge.
- Grant latency: `req` high at edge N (in IDLE) → `grant`, `busy`, LEDs valid after edge N+1.
- GRANT lasts DWELL×TICK_DIV cycles. GAP lasts TICK_DIV cycles.
- Early release: owner `req` low at edge N → `grant`=0 and LEDs=0 after edge N+1.
- `grant` and LEDs always change on the same edge. All outputs are registered, with no combinational path from inputs.

## Configuration
- Macro `LED_SCHED_BLINK_EN`.
- Defined: during GRANT, LEDs show the latched pattern on even ticks and 0 on odd ticks.
  - Phase resets at GRANT entry, so the first tick is lit.
  - `grant` is unaffected.
- Undefined: the pattern is steady for the whole grant and no blink logic is synthesized.

## Test plan
All scenarios use TICK_DIV=4, DWELL=3.
- **Reset:** hold `rst_n`=0 with `req`=4'hF → all outputs 0. Release, then 1 edge → `grant`=0001.
- **Dwell and gap:** `req`=0001, `pat[2:0]`=3'b101 → LED5=1, LED4=0, LED2=1 for 12 cycles; then 4 cycles all-off with `grant`=0; then regrant 0001.
- **Round-robin:** `req`=4'hF held → grant sequence 0001, 0010, 0100, 1000, 0001, with a 4-cycle gap between each.
- **Early release:** owner 0010 drops `req` 5 cycles into its grant → `grant`=0 one cycle later, then a 4-cycle gap, then the next pending channel.
- **Async reset mid-grant:** pulse `rst_n` low between edges during GRANT → LEDs and `grant` go 0 immediately; after release, arbitration restarts at channel 0.
- **Blink:** with `LED_SCHED_BLINK_EN` defined and `pat`=3'b111 → LEDs on/off/on across three 4-cycle ticks.

Source files
------------

// File: rtl/led_scheduler.sv
// Round-robin owner of LED5/LED4/LED2 across four pattern requesters.
// Ports: clk, rst_n, req[3:0], pat[11:0] in; grant[3:0], busy, LED5/4/2 out.
// Optional macro LED_SCHED_BLINK_EN blinks the granted pattern by tick.
module led_scheduler #(
  parameter int TICK_DIV = 12000,
  parameter int DWELL    = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] pat,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        LED5,
  output logic        LED4,
  output logic        LED2
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [2:0]      led_q, led_d;
  logic [1:0]      last_q, last_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dwell_q, dwell_d;
`ifdef LED_SCHED_BLINK_EN
  logic [2:0]      pat_q, pat_d;
`endif

  logic            tick;
  logic            own;
  logic [DW-1:0]   dwell_nx;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      idx;
  logic [2:0]      win_pat;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign own      = |(grant_q & req);
  assign dwell_nx = dwell_q + DW'(1);

  // Search begins one past the previous owner; k=4 wraps to last itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_pat = pat[2:0];
    unique case (win_idx)
      2'd0: win_pat = pat[2:0];
      2'd1: win_pat = pat[5:3];
      2'd2: win_pat = pat[8:6];
      2'd3: win_pat = pat[11:9];
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    last_d  = last_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    dwell_d = dwell_q;
`ifdef LED_SCHED_BLINK_EN
    pat_d   = pat_q;
`endif
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (win_found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win_idx;
          last_d  = win_idx;
          led_d   = win_pat;
          dwell_d = '0;
`ifdef LED_SCHED_BLINK_EN
          pat_d   = win_pat;
`endif
        end
      end
      GRANT: begin
        // Owner drop and dwell expiry share one exit into GAP.
        if (!own || (tick && dwell_nx == DW'(DWELL))) begin
          state_d = GAP;
          grant_d = '0;
          led_d   = '0;
          presc_d = '0;
          dwell_d = '0;
        end else if (tick) begin
          dwell_d = dwell_nx;
`ifdef LED_SCHED_BLINK_EN
          led_d   = dwell_nx[0] ? 3'b000 : pat_q;
`endif
        end
      end
      GAP: begin
        if (tick) begin
          presc_d = '0;
          if (win_found) begin
            state_d = GRANT;
            grant_d = 4'b0001 << win_idx;
            last_d  = win_idx;
            led_d   = win_pat;
            dwell_d = '0;
`ifdef LED_SCHED_BLINK_EN
            pat_d   = win_pat;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        led_d   = '0;
        presc_d = '0;
        dwell_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= '0;
      last_q  <= 2'd3;
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
    end
  end

`ifdef LED_SCHED_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end
`endif

  assign grant = grant_q;
  assign busy  = busy_q;
  assign LED5  = led_q[2];
  assign LED4  = led_q[1];
  assign LED2  = led_q[0];

endmodule
